// File: rtl/uart_pkg.sv
// uart_pkg: constants shared with uart_top and scheduler FSM state encoding
package uart_pkg;
  localparam int DATA_WIDTH_NUMBER = 8;
  localparam int STOP_BITS_NUMBER = 2;
  localparam int CLK_FREQ_HZ = 100_000_000;
  typedef enum logic [2:0] {IDLE, ARB, LOAD, START, WAIT_DONE, GAP} sched_state_t;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr and wrapping modulo N
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_req
);
  localparam int GW = $clog2(N);
  logic [GW:0] idx;
  // walk offsets from farthest to nearest so the nearest requester at or after ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (GW + 1)'(i);
      idx = (idx >= (GW + 1)'(N)) ? idx - (GW + 1)'(N) : idx;
      grant = req[idx[GW-1:0]] ? idx[GW-1:0] : grant;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: per-packet round-robin sharing of one uart_top transmitter with done watchdog
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_NUMBER,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          uart_tx_start,
  output logic [DATA_WIDTH-1:0]         uart_data_in,
  input  logic                          uart_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);
  localparam int GW  = $clog2(NUM_REQ);
  localparam int WCW = $clog2(TIMEOUT_CYCLES);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_t          state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, ptr_q, ptr_d, pick, nxt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d, any_req, fin;
  logic [WCW-1:0]        wdog_q, wdog_d;
  logic [GCW-1:0]        gap_q, gap_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .grant(pick),
    .any_req(any_req)
  );

  assign nxt = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // next-state logic; fin marks the post-byte decision after done (and gap)
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    data_d = data_q;
    last_d = last_q;
    wdog_d = wdog_q;
    gap_d = gap_q;
    timeout_err = 1'b0;
    fin = 1'b0;
    case (state_q)
      IDLE: state_d = any_req ? ARB : IDLE;
      ARB: begin
        state_d = any_req ? LOAD : IDLE;
        grant_d = any_req ? pick : grant_q;
      end
      LOAD: if (req_valid[grant_q]) begin
        data_d = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        last_d = req_last[grant_q];
        state_d = START;
      end
      START: begin
        wdog_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        if (uart_tx_done) begin
          gap_d = '0;
          state_d = GAP;
          fin = (GAP_CYCLES == 0);
        end else if (wdog_q == WCW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          ptr_d = nxt;
          state_d = IDLE;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        fin = (gap_q == GCW'(GAP_CYCLES - 1));
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = last_q ? IDLE : LOAD;
      ptr_d = last_q ? nxt : ptr_q;
    end
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      wdog_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      last_q <= last_d;
      wdog_q <= wdog_d;
      gap_q <= gap_d;
    end
  end

  assign req_ready = (state_q == LOAD) ? NUM_REQ'(1) << grant_q : '0;
  assign uart_tx_start = (state_q == START);
  assign uart_data_in = data_q;
  assign grant_id = grant_q;
  assign busy = (state_q != IDLE);
endmodule
